// File: rtl/pb_event_queue_if.sv
// Keycode stream between the pushbutton queue and its consumer.
// The producer drives valid/code and the consumer drives ready.
interface pb_event_queue_if #(
  parameter int unsigned CODE_W = 5
);
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_ready;

  modport master (
    output key_valid,
    output key_code,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output key_ready
  );
endinterface

// File: rtl/pb_event_queue.sv
// Pushbutton front end: synchronise, debounce, edge pulses, and a keycode FIFO
// drained over a valid/ready stream.
module pb_event_queue #(
  parameter int unsigned N_CH            = 21,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned DEPTH           = 4,
  localparam int unsigned CODE_W         = $clog2(N_CH)
) (
  input  logic                  hz100,
  input  logic                  reset,
  input  logic [N_CH-1:0]       pb,
  output logic [N_CH-1:0]       level,
  output logic [N_CH-1:0]       press,
  output logic [N_CH-1:0]       release_pulse,
  output logic                  overflow,
  output logic                  multi,
  input  logic                  clr_flags,
  pb_event_queue_if.master      key_if
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [N_CH-1:0]   sync_q [SYNC_STAGES];
  logic [N_CH-1:0]   s;
  logic [CNT_W-1:0]  cnt_q  [N_CH];
  logic [CNT_W-1:0]  cnt_d  [N_CH];
  logic [N_CH-1:0]   level_q, level_d, level_prev_q;

  logic [CODE_W-1:0] mem_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, multi_q;

  logic [CODE_W-1:0] enc_code;
  logic              push_req, multi_evt, full, pop, do_push, ovf_evt, key_valid;

  // Synchroniser chain
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pb;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Counter only advances while s disagrees with level; any agreement restarts it
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level         = level_q;
  assign press         = level_q & ~level_prev_q;
  assign release_pulse = ~level_q & level_prev_q;

  // Lowest set index wins
  always_comb begin
    enc_code = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press[i]) enc_code = CODE_W'(i);
    end
  end

  assign push_req  = |press;
  assign multi_evt = |(press & (press - N_CH'(1)));

  assign key_valid = (count_q != '0);
  assign full      = (count_q == FULL_CNT);
  assign pop       = key_valid & key_if.key_ready;
  // When full, a push is only accepted if the head leaves in the same cycle
  assign do_push   = push_req & (~full | pop);
  assign ovf_evt   = push_req & full & ~pop;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge hz100) begin
    if (do_push) mem_q[wr_ptr_q] <= enc_code;
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      overflow_q <= (overflow_q & ~clr_flags) | ovf_evt;
      multi_q    <= (multi_q & ~clr_flags) | multi_evt;
    end
  end

  assign overflow         = overflow_q;
  assign multi            = multi_q;
  assign key_if.key_valid = key_valid;
  assign key_if.key_code  = key_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_pb_event_queue.sv
// Directed bench for pb_event_queue with default parameters.
module tb_pb_event_queue;

  localparam int unsigned N_CH   = 21;
  localparam int unsigned CODE_W = 5;

  logic            hz100     = 1'b0;
  logic            reset     = 1'b0;
  logic [N_CH-1:0] pb        = '0;
  logic            clr_flags = 1'b0;
  logic [N_CH-1:0] level, press, rls;
  logic            overflow, multi;

  logic [N_CH-1:0] seen;
  logic            seen_v;
  int              checks = 0;
  int              errors = 0;
  int              exp_codes [4];

  pb_event_queue_if #(.CODE_W(CODE_W)) key_if ();

  pb_event_queue dut (
    .hz100         (hz100),
    .reset         (reset),
    .pb            (pb),
    .level         (level),
    .press         (press),
    .release_pulse (rls),
    .overflow      (overflow),
    .multi         (multi),
    .clr_flags     (clr_flags),
    .key_if        (key_if)
  );

  always #5 hz100 = ~hz100;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hz100);
    #1;
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      tick();
      seen   = seen | level | press | rls;
      seen_v = seen_v | key_if.key_valid;
    end
  endtask

  task automatic hold_button(input int ch);
    pb[ch] = 1'b1;
    repeat (8) tick();
    pb[ch] = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    key_if.key_ready = 1'b0;
    repeat (2) tick();
    check("rst_level", 32'(level), 0);
    check("rst_press", 32'(press), 0);
    check("rst_valid", 32'(key_if.key_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_multi", 32'(multi), 0);
    reset = 1'b1;
    repeat (2) tick();

    // Single press of channel 5
    pb[5] = 1'b1;
    repeat (4) tick();
    check("t1_level_edge4", 32'(level), 0);
    tick();
    check("t1_level_edge5", 32'(level), 32'h20);
    check("t1_press", 32'(press), 32'h20);
    check("t1_valid_edge5", 32'(key_if.key_valid), 0);
    tick();
    check("t1_press_once", 32'(press), 0);
    check("t1_valid_edge6", 32'(key_if.key_valid), 1);
    check("t1_code", 32'(key_if.key_code), 5);
    key_if.key_ready = 1'b1;
    tick();
    key_if.key_ready = 1'b0;
    check("t1_popped", 32'(key_if.key_valid), 0);

    // Release of channel 5
    pb[5] = 1'b0;
    repeat (4) tick();
    check("t3_rel_edge4", 32'(rls), 0);
    tick();
    check("t3_rel_edge5", 32'(rls), 32'h20);
    check("t3_level", 32'(level), 0);
    tick();
    check("t3_rel_once", 32'(rls), 0);
    check("t3_no_push", 32'(key_if.key_valid), 0);

    // Bounce on channel 3
    seen   = '0;
    seen_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pb[3] = (k % 2 == 0);
      watch(1);
    end
    pb[3] = 1'b0;
    watch(10);
    check("t2_bounce_outputs", 32'(seen), 0);
    check("t2_bounce_valid", 32'(seen_v), 0);
    pb[3] = 1'b1;
    watch(2);
    pb[3] = 1'b0;
    watch(10);
    check("t2_short_outputs", 32'(seen), 0);
    check("t2_short_valid", 32'(seen_v), 0);

    // Fill FIFO, then overflow
    hold_button(1);
    hold_button(2);
    hold_button(3);
    hold_button(4);
    check("t4_no_overflow", 32'(overflow), 0);
    check("t4_head_before", 32'(key_if.key_code), 1);
    hold_button(7);
    check("t4_overflow", 32'(overflow), 1);
    check("t4_head_kept", 32'(key_if.key_code), 1);
    exp_codes = '{1, 2, 3, 4};
    key_if.key_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t4_pop_valid", 32'(key_if.key_valid), 1);
      check("t4_pop_code", 32'(key_if.key_code), 32'(exp_codes[k]));
      tick();
    end
    check("t4_empty", 32'(key_if.key_valid), 0);
    tick();
    key_if.key_ready = 1'b0;
    check("t4_no_underflow", 32'(key_if.key_valid), 0);
    check("t4_overflow_sticky", 32'(overflow), 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t4_overflow_clr", 32'(overflow), 0);

    // Simultaneous presses on 9 and 2
    pb[9] = 1'b1;
    pb[2] = 1'b1;
    repeat (8) tick();
    check("t5_multi", 32'(multi), 1);
    check("t5_valid", 32'(key_if.key_valid), 1);
    check("t5_code", 32'(key_if.key_code), 2);
    pb[9] = 1'b0;
    pb[2] = 1'b0;
    repeat (8) tick();
    key_if.key_ready = 1'b1;
    tick();
    key_if.key_ready = 1'b0;
    check("t5_single_entry", 32'(key_if.key_valid), 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t5_multi_clr", 32'(multi), 0);

    // Set event coincident with clear keeps the flag
    pb[9] = 1'b1;
    pb[2] = 1'b1;
    repeat (5) tick();
    check("t5_press_pair", 32'(press), 32'h204);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    check("t5_set_wins", 32'(multi), 1);
    pb[9] = 1'b0;
    pb[2] = 1'b0;
    repeat (8) tick();
    key_if.key_ready = 1'b1;
    tick();
    key_if.key_ready = 1'b0;
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;

    // Full FIFO with simultaneous push and pop
    hold_button(10);
    hold_button(11);
    hold_button(12);
    hold_button(13);
    check("t6_head", 32'(key_if.key_code), 10);
    pb[0] = 1'b1;
    repeat (5) tick();
    check("t6_press", 32'(press), 1);
    key_if.key_ready = 1'b1;
    tick();
    key_if.key_ready = 1'b0;
    check("t6_valid", 32'(key_if.key_valid), 1);
    check("t6_head_next", 32'(key_if.key_code), 11);
    check("t6_no_overflow", 32'(overflow), 0);
    pb[0] = 1'b0;
    repeat (8) tick();
    hold_button(1);
    check("t6_still_full", 32'(overflow), 1);
    check("t6_head_kept", 32'(key_if.key_code), 11);

    // Reset mid-stream with debounce in progress
    pb[6] = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(key_if.key_valid), 0);
    check("t6_rst_level", 32'(level), 0);
    check("t6_rst_overflow", 32'(overflow), 0);
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check("t6_post_level_edge4", 32'(level), 0);
    check("t6_post_overflow", 32'(overflow), 0);
    check("t6_post_valid", 32'(key_if.key_valid), 0);
    tick();
    check("t6_post_level_edge5", 32'(level), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_event_queue.md
Name: pb_event_queue

Overview:
Parametrised pushbutton front end for the board top level. It replaces direct use of raw `pb` bits.
- Synchronises and debounces N_CH button inputs.
- Produces clean level, press-pulse and release-pulse vectors.
- Encodes each press into a keycode and buffers the keycodes in a small FIFO.
- The FIFO is drained with a valid/ready handshake by downstream logic (display, CPU, UART bridge).

Parameters:
- N_CH, 21: number of button channels, 2..32.
- SYNC_STAGES, 2: synchroniser flops per channel, at least 2.
- DEBOUNCE_CYCLES, 3: consecutive stable synchronised cycles required before a level change is accepted, at least 1.
- DEPTH, 4: keycode FIFO entries, power of 2, at least 2.
- CODE_W (localparam), $clog2(N_CH): keycode width.

Ports:
- hz100, input, 1: system clock, all state on rising edge.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- pb, input, N_CH: raw asynchronous button inputs, 1 = pressed.
- level, output, N_CH: debounced button levels.
- press, output, N_CH: one-cycle pulse on each debounced 0->1 transition.
- release, output, N_CH: one-cycle pulse on each debounced 1->0 transition.
- key_valid, output, 1: FIFO non-empty.
- key_code, output, CODE_W: keycode at the FIFO head; index of the pressed channel.
- key_ready, input, 1: consumer accepts the head entry.
- overflow, output, 1: sticky; a press was lost because the FIFO was full.
- multi, output, 1: sticky; two or more presses occurred in the same cycle.
- clr_flags, input, 1: synchronous clear of `overflow` and `multi`.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears synchroniser flops, debounce counters, level, the previous-level register, FIFO pointers/count, overflow and multi.
  - Outputs read 0 while reset is held.
  - A reset mid-operation discards all queued keys and all debounce progress.
- Synchroniser: SYNC_STAGES-deep flop chain per bit; `s[i]` is the last stage.
- Debounce, per channel:
  - If s[i]==level[i], the counter is set to 0.
  - Otherwise, if the counter equals DEBOUNCE_CYCLES-1, then level[i]<=s[i] and the counter is set to 0; else the counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches `level`.
  - Latency: a pb change set up before edge 0 appears on `level` after edge SYNC_STAGES+DEBOUNCE_CYCLES (default: edge 5).
- Pulses:
  - press = level & ~level_d; release = ~level & level_d, where level_d is `level` registered one cycle.
  - Each pulse is high exactly during the first cycle of the new level.
- Encoder:
  - When press != 0, the candidate keycode is the lowest set index of `press`.
  - If more than one press bit is set, only the lowest is queued and `multi` sets.
- FIFO push and pop:
  - Push when press!=0. Pop when key_valid & key_ready.
  - key_code is the head entry, valid only when key_valid=1.
  - Push into an empty FIFO gives key_valid=1 on the next edge (default: edge 6 after the pb change).
- Full / empty cases:
  - Full, push and pop in the same cycle: both happen, count unchanged.
  - Full, push without pop: push dropped, `overflow` sets, FIFO contents unchanged.
  - Empty and key_ready=1: no effect; count never underflows.
  - Pointers wrap modulo DEPTH; count is tracked separately, range 0..DEPTH.
- Flags:
  - clr_flags clears `overflow`/`multi` on the next edge.
  - A set event in the same cycle as clr_flags wins; the flag stays 1.

Test Plan (all with default parameters):
1. Reset, then hold pb[5]=1:
   - level[5] rises after edge 5; press[5]=1 for exactly 1 cycle.
   - key_valid=1 with key_code=5 after edge 6.
   - key_ready=1 for 1 cycle gives key_valid=0.
2. Bounce: pb[3] toggles 1,0,1,0 on successive cycles, then holds 0:
   - level stays 0; press, release and key_valid never assert.
   - pb[3]=1 held for exactly 2 synchronised cycles also gives no change.
3. Release of a held pb[5]:
   - release[5] pulses 1 cycle, 5 edges after pb falls.
   - No FIFO entry is written.
4. With key_ready=0, press channels 1,2,3,4,7 sequentially:
   - FIFO fills with 1,2,3,4; the 7 press sets overflow=1.
   - Popping yields 1,2,3,4 in order, then key_valid=0.
   - clr_flags gives overflow=0.
5. pb[9] and pb[2] rise in the same cycle:
   - Only keycode 2 is queued; multi=1.
6. FIFO full with key_ready=1 held, new press on pb[0]:
   - Head pops and 0 is appended; count stays 4; overflow stays 0.
   - Then assert reset=0 mid-stream: key_valid=0 immediately, and level=0, overflow=0 after release.
